// File: rtl/manchester_encoder.sv
// Transmit framer and Manchester line encoder: preamble, start word, then FRAME_SIZE+1
// logical payload bytes from an AXI-Stream slave, MSB first, one half-bit per clock.
module manchester_encoder #(
    parameter int         FRAME_SIZE       = 64,
    parameter int         PREAMBLE_BYTES   = 4,
    parameter logic [7:0] START_WORD       = 8'hD5,
    parameter logic [7:0] PREAMBLE_PATTERN = 8'hAA,
    parameter logic [7:0] ESCAPE_SYMBOL    = 8'hE5,
    parameter logic [7:0] REPLACE_SYMBOL   = 8'hF5
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       manchester_out,
    output logic       busy,
    output logic       frame_done,
    output logic       err_symbol
);

    localparam int              PW        = $clog2(PREAMBLE_BYTES);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(PREAMBLE_BYTES - 1);
    localparam logic [8:0]      LAST_BYTE = 9'(FRAME_SIZE);

    typedef enum logic [1:0] {IDLE, PREAMBLE, START, PAYLOAD} state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    half_cnt;
    logic [PW-1:0] pre_cnt;
    logic [8:0]    byte_cnt;
    logic [7:0]    cur_byte;
    logic          cur_filler;
    logic          slot_end;
    logic          fetch;
    logic          last_slot;
    logic          line_bit;
    logic [7:0]    fetch_byte;
    logic [7:0]    tx_byte;

    // The state machine runs one cycle ahead of the registered line, so the fetch cycle
    // (first state cycle of a payload slot) lines up with the last half-bit on the wire.
    assign slot_end      = (half_cnt == 4'd15);
    assign fetch         = (state == PAYLOAD) && (half_cnt == 4'd0);
    assign last_slot     = (state == PAYLOAD) && !cur_filler && (byte_cnt == LAST_BYTE);
    assign s_axis_tready = fetch;
    assign err_symbol    = fetch && s_axis_tvalid &&
                           ((s_axis_tdata == ESCAPE_SYMBOL) || (s_axis_tdata == REPLACE_SYMBOL));

    always_comb begin
        fetch_byte = ESCAPE_SYMBOL;
        if (s_axis_tvalid) begin
            fetch_byte = (s_axis_tdata == START_WORD) ? REPLACE_SYMBOL : s_axis_tdata;
        end
    end

    // The fetched byte bypasses cur_byte so its first half-bit goes out without a bubble.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            PREAMBLE: tx_byte = PREAMBLE_PATTERN;
            START:    tx_byte = START_WORD;
            PAYLOAD:  tx_byte = fetch ? fetch_byte : cur_byte;
            default:  tx_byte = 8'h00;
        endcase
    end

    assign line_bit = tx_byte[~half_cnt[3:1]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (s_axis_tvalid) state_next = PREAMBLE;
            PREAMBLE: if (slot_end && (pre_cnt == PRE_LAST)) state_next = START;
            START:    if (slot_end) state_next = PAYLOAD;
            PAYLOAD:  if (slot_end && last_slot) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            half_cnt   <= 4'd0;
            pre_cnt    <= '0;
            byte_cnt   <= 9'd0;
            cur_byte   <= 8'h00;
            cur_filler <= 1'b0;
        end else begin
            half_cnt <= (state == IDLE) ? 4'd0 : half_cnt + 4'd1;
            if (state != PREAMBLE) begin
                pre_cnt <= '0;
            end else if (slot_end) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (state != PAYLOAD) begin
                byte_cnt <= 9'd0;
            end else if (slot_end && !cur_filler) begin
                byte_cnt <= byte_cnt + 9'd1;
            end
            if (fetch) begin
                cur_byte   <= fetch_byte;
                cur_filler <= !s_axis_tvalid;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            manchester_out <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            manchester_out <= (state != IDLE) && (half_cnt[0] ? line_bit : ~line_bit);
            busy           <= (state != IDLE);
            frame_done     <= slot_end && last_slot;
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// Bench for manchester_encoder: slot-level reference model checked every cycle, plus
// literal per-frame expectations (length, handshakes, slot bytes) for directed frames.
module tb_manchester_encoder;

    localparam int FS = 3;
    localparam int PB = 4;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       manchester_out;
    logic       busy;
    logic       frame_done;
    logic       err_symbol;

    int assertions = 0;
    int failures = 0;

    logic [7:0] src_q[$];

    bit         lit_valid = 1'b0;
    int         lit_len = 0;
    int         lit_err = 0;
    int         lit_n = 0;
    logic [7:0] lit_slots[16];

    bit         m_pend = 1'b0;
    bit         m_act = 1'b0;
    int         m_t = 0;
    int         m_slot = 0;
    int         m_logical = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_fill = 1'b0;
    logic       e_out, e_busy, e_tready, e_done, e_err, bitv;
    bit         is_pay, start_ok;

    int         mon_cnt = 0;
    int         mon_hs = 0;
    int         mon_err = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_q[$];

    manchester_encoder #(
        .FRAME_SIZE(FS),
        .PREAMBLE_BYTES(PB)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .manchester_out(manchester_out),
        .busy(busy),
        .frame_done(frame_done),
        .err_symbol(err_symbol)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            checkOutput("rst_line", 32'(manchester_out), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
            checkOutput("rst_done", 32'(frame_done), 32'd0);
            checkOutput("rst_err", 32'(err_symbol), 32'd0);
            m_pend = 1'b0;
            m_act = 1'b0;
            mon_cnt = 0; mon_hs = 0; mon_err = 0;
            mon_q.delete();
        end else begin
            e_out = 1'b0; e_busy = 1'b0; e_tready = 1'b0; e_done = 1'b0;
            is_pay = (m_slot > PB);
            if (m_act) begin
                bitv     = m_byte[7 - m_t / 2];
                e_out    = (m_t % 2 == 1) ? bitv : !bitv;
                e_busy   = 1'b1;
                e_done   = (m_t == 15) && is_pay && !m_fill && (m_logical == FS);
                e_tready = (m_t == 15) && (m_slot == PB || (is_pay && !e_done));
            end
            e_err = e_tready && s_axis_tvalid &&
                    (s_axis_tdata == 8'hE5 || s_axis_tdata == 8'hF5);
            checkOutput("line", 32'(manchester_out), 32'(e_out));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("tready", 32'(s_axis_tready), 32'(e_tready));
            checkOutput("frame_done", 32'(frame_done), 32'(e_done));
            checkOutput("err_symbol", 32'(err_symbol), 32'(e_err));

            // Advance the model by one cycle.
            start_ok = (!m_act && !m_pend) || e_done;
            if (m_pend) begin
                m_pend = 1'b0; m_act = 1'b1; m_t = 0; m_slot = 0;
                m_byte = 8'hAA; m_fill = 1'b0; m_logical = 0;
            end else if (m_act) begin
                if (m_t == 15) begin
                    m_t = 0;
                    if (e_done) begin
                        m_act = 1'b0;
                    end else begin
                        if (is_pay && !m_fill) m_logical++;
                        m_slot++;
                        if (m_slot < PB) m_byte = 8'hAA;
                        else if (m_slot == PB) m_byte = 8'hD5;
                        else begin
                            m_fill = !s_axis_tvalid;
                            m_byte = !s_axis_tvalid ? 8'hE5 :
                                     (s_axis_tdata == 8'hD5) ? 8'hF5 : s_axis_tdata;
                        end
                    end
                end else begin
                    m_t++;
                end
            end
            if (start_ok && s_axis_tvalid) m_pend = 1'b1;

            // Independent line decoder for the literal per-frame checks.
            if (busy) begin
                if (mon_cnt % 2 == 1) mon_byte = {mon_byte[6:0], manchester_out};
                if (mon_cnt % 16 == 15) mon_q.push_back(mon_byte);
                mon_cnt++;
                if (s_axis_tvalid && s_axis_tready) mon_hs++;
                if (err_symbol) mon_err++;
                if (frame_done && lit_valid) begin
                    checkOutput("lit_len", 32'(mon_cnt), 32'(lit_len));
                    checkOutput("lit_hs", 32'(mon_hs), 32'(FS + 1));
                    checkOutput("lit_err", 32'(mon_err), 32'(lit_err));
                    checkOutput("lit_nslots", 32'(mon_q.size()), 32'(lit_n));
                    for (int i = 0; i < mon_q.size() && i < 16; i++) begin
                        checkOutput("lit_slot", 32'(mon_q[i]), 32'(lit_slots[i]));
                    end
                end
            end else begin
                mon_cnt = 0; mon_hs = 0; mon_err = 0;
                mon_q.delete();
            end
        end
    end

    task automatic setLit(input int len, input int err, input int npay,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] p3, input logic [7:0] p4);
        for (int i = 0; i < PB; i++) lit_slots[i] = 8'hAA;
        lit_slots[PB]     = 8'hD5;
        lit_slots[PB + 1] = p0;
        lit_slots[PB + 2] = p1;
        lit_slots[PB + 3] = p2;
        lit_slots[PB + 4] = p3;
        lit_slots[PB + 5] = p4;
        lit_len = len;
        lit_err = err;
        lit_n = PB + 1 + npay;
        lit_valid = 1'b1;
    endtask

    // Source model: presents the queue head; drop_idx forces one underrun after that many accepts.
    task automatic applyStimulus(input int cycles, input int valid_pct, input int drop_idx);
        int accepted = 0;
        bit dropped = 1'b0;
        bit hs;
        for (int c = 0; c < cycles; c++) begin
            if (src_q.size() == 0) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata = 8'h00;
            end else begin
                s_axis_tvalid = ($urandom_range(0, 99) < valid_pct);
                s_axis_tdata = src_q[0];
            end
            if (!dropped && accepted == drop_idx && s_axis_tready && s_axis_tvalid) begin
                s_axis_tvalid = 1'b0;
                dropped = 1'b1;
            end
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                accepted++;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    function automatic logic [7:0] randByte();
        case ($urandom_range(0, 7))
            0: return 8'hD5;
            1: return 8'hE5;
            2: return 8'hF5;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        $display("[TB] basic frame");
        setLit(144, 0, 4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(200, 100, -1);

        $display("[TB] underrun frame");
        setLit(160, 0, 5, 8'h11, 8'hE5, 8'h22, 8'h33, 8'h44);
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(220, 100, 1);

        $display("[TB] substitution and illegal symbols");
        setLit(144, 2, 4, 8'hF5, 8'hE5, 8'hF5, 8'h07, 8'h00);
        src_q = '{8'hD5, 8'hE5, 8'hF5, 8'h07};
        applyStimulus(200, 100, -1);

        $display("[TB] back-to-back frames");
        setLit(144, 0, 4, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00);
        src_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
        applyStimulus(340, 100, -1);
        lit_valid = 1'b0;

        $display("[TB] reset mid-preamble");
        src_q = '{8'h81, 8'h42, 8'h24, 8'h18};
        applyStimulus(30, 100, -1);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        applyStimulus(200, 100, -1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 6; f++) begin
            int n;
            n = 4 * $urandom_range(1, 2);
            for (int i = 0; i < n; i++) src_q.push_back(randByte());
            applyStimulus(n * 50 + 40, $urandom_range(50, 100), -1);
        end
        applyStimulus(700, 100, -1);

        repeat (2) @(negedge aclk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
